nibble_serial_adder: RTL

- Sequential multi-precision add/subtract controller.
- Sits directly upstream of the team's 4-bit ripple-carry adder.
  - Slices wide operands into nibbles and feeds them to the adder one nibble per clock, LSB first.
  - Consumes the adder's sum/carry-out, registers the partial results and chains the carry.
- Wide operands are accepted and results returned over valid/ready handshakes.

---
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract sequencer. It feeds an external 4-bit ripple adder
// one nibble per clock, LSB first, and chains the carry between nibbles.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_ovf;
  logic [IW+1:0]   w_nibBase;
  logic            w_last;

  assign w_nibBase = {r_idx, 2'b00};
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) w_nextState = RUN;
      end
      RUN: begin
        add_a   = r_a[w_nibBase +: 4];
        add_b   = r_b[w_nibBase +: 4];
        add_cin = r_carry;
        if (w_last) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_result[w_nibBase +: 4] <= add_sum;
          r_carry                  <= add_cout;
          if (w_last) begin
            r_cout <= add_cout;
            r_ovf  <= (r_a[W-1] ~^ r_b[W-1]) & (r_a[W-1] ^ add_sum[3]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
